// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the memory-access stage, the external loader port and the data RAM.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              core_en;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  core_en, core_we, core_addr, core_wdata,
    output core_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output core_en, core_we, core_addr, core_wdata,
    input  core_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: core has fixed priority, the external port gets a forced one-cycle
// grant after MAX_WAIT consecutive denied cycles. External read data returns one cycle later.
module dmem_arbiter #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  dmem_arbiter_if.slave bus
);

  logic [3:0]        waitCnt;
  logic              extRdPend;
  logic              forceGnt;
  logic              selExt;
  logic              weMux;
  logic [ADDR_W-1:0] addrMux;
  logic [DATA_W-1:0] wdataMux;

  always_comb begin
    forceGnt = bus.ext_req && (waitCnt == 4'(MAX_WAIT));
    selExt   = bus.ext_req && (!bus.core_en || forceGnt);
    if (selExt) begin
      weMux    = bus.ext_we;
      addrMux  = bus.ext_addr;
      wdataMux = bus.ext_wdata;
    end else begin
      weMux    = bus.core_en & bus.core_we;
      addrMux  = bus.core_addr;
      wdataMux = bus.core_wdata;
    end
  end

  assign bus.ext_gnt    = selExt;
  assign bus.core_stall = bus.core_en && selExt;
  assign bus.ram_we     = weMux;
  assign bus.ram_addr   = addrMux;
  assign bus.ram_wdata  = wdataMux;
  assign bus.ext_rvalid = extRdPend;
  assign bus.ext_rdata  = bus.ram_rdata;

  // Clearing on every grant keeps waitCnt bounded by MAX_WAIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      waitCnt   <= '0;
      extRdPend <= 1'b0;
    end else begin
      if (!bus.ext_req || selExt)
        waitCnt <= '0;
      else
        waitCnt <= waitCnt + 4'd1;
      extRdPend <= selExt & ~bus.ext_we;
    end
  end

endmodule
